// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo
// ----------------------------------------------------------------------------
// 16x-oversampled UART receiver with configurable frame format, a DEPTH-entry
// first-word fall-through receive FIFO with pop handshake, and a rolling
// history window of the last DEPTH good bytes for the 7-segment display path.
//
// Optional feature macro: UART_RX_HIST_EN
//   defined   -> hist carries the last DEPTH good bytes
//   undefined -> hist is tied to zero and no history registers are built
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   BAUD       line rate; tick divider DIV = CLK_HZ/(BAUD*16), DIV >= 1
//   DATA_BITS  data bits per frame, 5..8
//   PARITY     0 none, 1 even, 2 odd
//   DEPTH      FIFO and history depth, power of 2, >= 2
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous active-high reset
//   rxd        serial input, idle high, asynchronous to clk
//   rd_en      pop request for the FIFO head
//   rd_data    FIFO head byte, valid while empty=0
//   empty      FIFO empty
//   full       FIFO full
//   count      FIFO occupancy, 0..DEPTH
//   rx_valid   one-cycle pulse per good byte
//   rx_byte    last good byte, held until the next one
//   hist       last DEPTH good bytes, newest in [7:0], lanes zero-extended
//   frame_err  one-cycle pulse on a bad stop bit
//   parity_err one-cycle pulse on a parity mismatch
//   overrun    one-cycle pulse when a good byte is dropped on a full FIFO
// ============================================================================
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rxd,
    input  logic                       rd_en,
    output logic [DATA_BITS-1:0]       rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       rx_valid,
    output logic [DATA_BITS-1:0]       rx_byte,
    output logic [8*DEPTH-1:0]         hist,
    output logic                       frame_err,
    output logic                       parity_err,
    output logic                       overrun
);

    localparam int unsigned DIV   = CLK_HZ / (BAUD * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam bit          ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; both flops reset to the idle level.
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2;
    logic line;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
        end
    end

    assign line = rx_s2;

    // ------------------------------------------------------------------
    // 16x oversampling tick.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t               state, state_n;
    logic [3:0]           sc, sc_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_fail, par_fail_n;
    logic                 accept;
    logic                 ferr_det;
    logic                 perr_det;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sc       <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_fail <= 1'b0;
        end else begin
            state    <= state_n;
            sc       <= sc_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            par_fail <= par_fail_n;
        end
    end

    always_comb begin
        state_n    = state;
        sc_n       = sc;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        par_fail_n = par_fail;
        accept     = 1'b0;
        ferr_det   = 1'b0;
        perr_det   = 1'b0;

        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!line) begin
                        state_n = S_START;
                        sc_n    = '0;
                    end
                end

                // Re-check the line at mid start bit to reject glitches.
                S_START: begin
                    if (sc == 4'd7) begin
                        sc_n = '0;
                        if (!line) begin
                            state_n    = S_DATA;
                            bit_idx_n  = '0;
                            par_fail_n = 1'b0;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        sc_n = sc + 4'd1;
                    end
                end

                // LSB first: new bits enter at the top and shift down.
                S_DATA: begin
                    if (sc == 4'd15) begin
                        sc_n    = '0;
                        shreg_n = {line, shreg[DATA_BITS-1:1]};
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            bit_idx_n = '0;
                            state_n   = (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_idx_n = bit_idx + 3'd1;
                        end
                    end else begin
                        sc_n = sc + 4'd1;
                    end
                end

                S_PAR: begin
                    if (sc == 4'd15) begin
                        sc_n       = '0;
                        par_fail_n = ((^shreg) ^ line) != ODD;
                        state_n    = S_STOP;
                    end else begin
                        sc_n = sc + 4'd1;
                    end
                end

                S_STOP: begin
                    if (sc == 4'd15) begin
                        sc_n = '0;
                        if (!line) begin
                            ferr_det = 1'b1;
                            state_n  = S_BREAK;
                        end else if (par_fail) begin
                            perr_det = 1'b1;
                            state_n  = S_IDLE;
                        end else begin
                            accept  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        sc_n = sc + 4'd1;
                    end
                end

                S_BREAK: begin
                    if (line) begin
                        state_n = S_IDLE;
                    end
                end

                default: begin
                    state_n = S_IDLE;
                    sc_n    = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        cnt;
    logic                 pop;
    logic                 push;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // A pop on the same cycle frees the slot, so a full FIFO still accepts.
    assign pop  = rd_en && !empty;
    assign push = accept && (!full || pop);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status pulses and last-byte register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid   <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_valid   <= accept;
            frame_err  <= ferr_det;
            parity_err <= perr_det;
            overrun    <= accept && !push;
            if (accept) begin
                rx_byte <= shreg;
            end
        end
    end

    // ------------------------------------------------------------------
    // History window
    // ------------------------------------------------------------------
`ifdef UART_RX_HIST_EN
    logic [7:0]         byte_lane;
    logic [8*DEPTH-1:0] hist_r;

    always_comb begin
        byte_lane                = '0;
        byte_lane[DATA_BITS-1:0] = shreg;
    end

    // Updates on every good byte, independent of FIFO space.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r <= '0;
        end else if (accept) begin
            hist_r <= {hist_r[8*DEPTH-9:0], byte_lane};
        end
    end

    assign hist = hist_r;
`else
    assign hist = '0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receive block: 16x-oversampled receiver with configurable frame format, a DEPTH-entry receive FIFO with pop handshake, and a rolling history window of the last DEPTH good bytes for the dual 7-segment display path. It sits between the board RX pin and the application logic or display drivers. It replaces the fixed 8N1 receiver, which had a hard 4-byte capture buffer and no flow control.

## Interface
- CLK_HZ, 100000000, system clock frequency in Hz
- BAUD, 9600, line rate; tick divider DIV = CLK_HZ/(BAUD*16), truncated, DIV ≥ 1
- DATA_BITS, 8, data bits per frame, 5..8
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd
- DEPTH, 4, FIFO and history depth; power of 2, ≥ 2
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- rxd  in  1  serial input, idle high, asynchronous to clk
- rd_en  in  1  pop request for the FIFO head
- rd_data  out  DATA_BITS  FIFO head byte; valid while empty=0
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- rx_valid  out  1  one-cycle pulse when a good byte completes
- rx_byte  out  DATA_BITS  last good byte; held until the next good byte
- hist  out  8*DEPTH  last DEPTH good bytes; newest in [7:0], older bytes in higher lanes; each lane zero-extended
- frame_err  out  1  one-cycle pulse when a frame error is detected
- parity_err  out  1  one-cycle pulse when a parity error is detected
- overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full

## Operation
- **Input sync:** rxd passes through a 2-flop synchronizer. Both flops reset to 1. All FSM samples use the synchronized value.
- **Tick generator:** free-running counter 0..DIV-1. The tick fires on the cycle the counter equals DIV-1. The counter clears on rst.
- **FSM states:** IDLE, START, DATA, PAR, STOP, BREAK. A tick counter `sc` (0..15) and a bit index run inside the FSM.
  - IDLE: on a tick with line=0, go to START with sc=0.
  - START: at sc=7, if line=0, go to DATA with sc=0; otherwise return to IDLE (glitch rejected, no flags).
  - DATA: sample at sc=15, LSB first. After DATA_BITS samples, go to PAR if PARITY≠0, else to STOP.
  - PAR: sample at sc=15. Even parity means data XOR parity bit = 0; odd parity means it = 1. A mismatch latches a parity-fail bit; the state then goes to STOP.
  - STOP: sample at sc=15. Line=0 gives a frame_err pulse, discards the byte and goes to BREAK. Line=1 with the parity-fail bit set gives a parity_err pulse, discards the byte and goes to IDLE. Line=1 otherwise accepts the byte and goes to IDLE.
  - BREAK: wait for a tick with line=1, then go to IDLE.
- **On an accepted byte, in the same clk:**
  - rx_valid=1 and rx_byte is updated.
  - hist shifts up one lane and the new byte enters [7:0].
  - The byte is pushed to the FIFO if not full; if full, an overrun pulse is raised and the byte is dropped.
  - hist updates even when the FIFO is full.
- **FIFO:** first-word fall-through. rd_data always shows the head entry.
  - rd_en with empty=0 pops the head. rd_en with empty=1 is ignored.
  - Push and pop in the same cycle while full: both occur, count is unchanged, no overrun.
  - Push and pop in the same cycle while empty: only the push occurs.
  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
  - full = (count==DEPTH). empty = (count==0).

## Timing
- **Reset values:** rd_data=0, empty=1, full=0, count=0, rx_valid=0, rx_byte=0, hist=0, frame_err=0, parity_err=0, overrun=0. FSM in IDLE, all counters 0.
- **Reset mid-frame:** the partial frame is discarded and the FIFO is flushed. Reception resumes from IDLE; the next falling edge after rst deasserts starts a new frame.
- **Input latency:** 2 clk for synchronization, plus up to one tick of start-edge quantisation.
- **Byte-complete latency:** the rx_valid, error and overrun pulses, the hist update and the push all register 1 clk after the stop-bit sample tick.
- **FIFO status after push:** empty, count and full reflect the push on the same edge that rx_valid is registered.
- **FIFO status after pop:** rd_data, count and empty reflect the pop 1 clk after the rd_en edge.
- **Sustained rate:** back-to-back frames with a single stop bit are received without loss, provided the consumer pops at least one byte per frame.

## Configuration
- **UART_RX_HIST_EN defined:** hist is implemented as described above.
- **UART_RX_HIST_EN undefined:** hist is tied to 0 and no history registers are built. All other behaviour is unchanged and the port list is unchanged.

## Test plan
All scenarios use CLK_HZ=1600000, BAUD=100000 (DIV=1, 16 clk per bit).
- **8N1 receive:** send 0xA5 with no pop → one rx_valid pulse, rx_byte=0xA5, rd_data=0xA5, count=1, hist[7:0]=0xA5.
- **Overrun:** DEPTH=4, send 0x01..0x05 with no pops → count=4 and full=1 after 0x04; overrun pulses on 0x05. hist={0x02,0x03,0x04,0x05} from high lane to low lane (lane 0 = 0x05). Four pops then return 0x01..0x04 in order and empty=1.
- **Even parity:** PARITY=1, send 0x03 with parity bit 1 → parity_err pulse, count stays 0. Then send 0x03 with parity bit 0 → byte accepted.
- **Frame error:** send a frame with stop bit 0, then hold the line low for 3 bit times → frame_err pulses once, no push. After the line returns high, 0x5A is received normally.
- **Glitch and mid-frame reset:** a 4-clk low pulse on an idle line → no flags, no byte. Asserting rst during data bit 3 of a frame → all outputs return to reset values; a subsequent 0x3C is received correctly.
- **Full with simultaneous pop:** with count=4, assert rd_en in the same clk the next byte's push registers → count stays 4, no overrun, and the head advances.
